// File: rtl/receiver_buffer_mem.sv
// Receive-side word buffer: random access by address, or stream (FIFO) access
// through internal pointers with occupancy count, full/empty and error strobes.
module receiver_buffer_mem #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mode_i,
  input  logic              clear_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic [ADDR_W:0]   count_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              wr_err_o,
  output logic              rd_err_o
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              wr_err_q, wr_err_d;
  logic              rd_err_q, rd_err_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic              wr_acc;
  logic              rd_acc;

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    wr_err_d   = 1'b0;
    rd_err_d   = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = addr_i;
    wr_acc     = 1'b0;
    rd_acc     = 1'b0;

    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else if (!mode_i) begin
      mem_we    = wr_en_i;
      mem_waddr = addr_i;
      if (rd_en_i) begin
        // Array write lands at the same edge, so this returns the old word.
        rd_data_d  = mem_q[addr_i];
        rd_valid_d = 1'b1;
      end
    end else begin
      // Acceptance uses the registered flags, i.e. the pre-edge occupancy.
      wr_acc = wr_en_i && !full_q;
      rd_acc = rd_en_i && !empty_q;
      wr_err_d = wr_en_i && full_q;
      rd_err_d = rd_en_i && empty_q;

      if (wr_acc) begin
        mem_we    = 1'b1;
        mem_waddr = wr_ptr_q;
        wr_ptr_d  = wr_ptr_q + 1'b1;
      end
      if (rd_acc) begin
        rd_data_d  = mem_q[rd_ptr_q];
        rd_valid_d = 1'b1;
        rd_ptr_d   = rd_ptr_q + 1'b1;
      end

      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    empty_d = (count_d == '0);
    full_d  = (count_d == FULL_CNT);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      wr_err_q   <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      wr_err_q   <= wr_err_d;
      rd_err_q   <= rd_err_d;
    end
  end

  // Array has no reset; contents survive both rst and clear.
  always_ff @(posedge clk_i) begin
    if (!rst_i && mem_we) begin
      mem_q[mem_waddr] <= wr_data_i;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign count_o    = count_q;
  assign empty_o    = empty_q;
  assign full_o     = full_q;
  assign wr_err_o   = wr_err_q;
  assign rd_err_o   = rd_err_q;

endmodule

// File: tb/tb_receiver_buffer_mem.sv
// Directed bench for receiver_buffer_mem (DATA_W=16, ADDR_W=4) with hand-computed expectations.
module tb_receiver_buffer_mem;

  logic        clk = 1'b0;
  logic        rst, mode, clear, wr_en, rd_en;
  logic [3:0]  addr;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic        rd_valid, empty, full, wr_err, rd_err;
  logic [4:0]  count;

  int checks = 0;
  int errors = 0;

  receiver_buffer_mem #(.DATA_W(16), .ADDR_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .mode_i(mode), .clear_i(clear), .addr_i(addr),
    .wr_en_i(wr_en), .wr_data_i(wr_data), .rd_en_i(rd_en),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid), .count_o(count),
    .empty_o(empty), .full_o(full), .wr_err_o(wr_err), .rd_err_o(rd_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply current inputs across one rising edge, then settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic m, input logic w, input logic r,
                       input logic [3:0] a, input logic [15:0] d);
    mode = m; wr_en = w; rd_en = r; addr = a; wr_data = d; clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 4'd0, 16'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_wr_err", wr_err, 0);
    check("rst_rd_err", rd_err, 0);

    // Random access
    drive(1'b0, 1'b1, 1'b0, 4'd3, 16'hA5A5); tick();
    check("rnd_wr_no_valid", rd_valid, 0);
    drive(1'b0, 1'b0, 1'b1, 4'd3, 16'h0); tick();
    check("rnd_rd_data", rd_data, 16'hA5A5);
    check("rnd_rd_valid", rd_valid, 1);
    drive(1'b0, 1'b1, 1'b1, 4'd3, 16'h1234); tick();
    check("rnd_rbw_data", rd_data, 16'hA5A5);
    check("rnd_rbw_valid", rd_valid, 1);
    drive(1'b0, 1'b0, 1'b1, 4'd3, 16'h0); tick();
    check("rnd_new_data", rd_data, 16'h1234);
    check("rnd_rd_err", rd_err, 0);
    drive(1'b0, 1'b0, 1'b0, 4'd3, 16'h0); tick();
    check("rnd_idle_valid", rd_valid, 0);
    check("rnd_idle_hold", rd_data, 16'h1234);
    check("rnd_count", count, 0);

    // Stream fill to full
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 1'b0, 4'd0, 16'(i)); tick();
    end
    check("fill_count", count, 16);
    check("fill_full", full, 1);
    check("fill_empty", empty, 0);
    drive(1'b1, 1'b1, 1'b0, 4'd0, 16'hDEAD); tick();
    check("ovf_wr_err", wr_err, 1);
    check("ovf_count", count, 16);
    drive(1'b1, 1'b0, 1'b0, 4'd0, 16'h0); tick();
    check("ovf_err_pulse", wr_err, 0);

    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 1'b1, 4'd0, 16'h0); tick();
      check($sformatf("drain_data%0d", i), rd_data, i);
      check($sformatf("drain_valid%0d", i), rd_valid, 1);
    end
    check("drain_empty", empty, 1);
    check("drain_count", count, 0);
    drive(1'b1, 1'b0, 1'b1, 4'd0, 16'h0); tick();
    check("udf_rd_err", rd_err, 1);
    check("udf_valid", rd_valid, 0);
    check("udf_hold", rd_data, 16'h000F);
    drive(1'b1, 1'b0, 1'b0, 4'd0, 16'h0); tick();
    check("udf_err_pulse", rd_err, 0);

    // Wrap-around
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b1, 1'b0, 4'd0, 16'h0100 + 16'(i)); tick();
    end
    check("wrap_count12", count, 12);
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b0, 1'b1, 4'd0, 16'h0); tick();
      check($sformatf("wrap_a%0d", i), rd_data, 16'h0100 + i);
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 1'b0, 4'd0, 16'h0200 + 16'(i)); tick();
    end
    check("wrap_count8", count, 8);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b1, 4'd0, 16'h0); tick();
      check($sformatf("wrap_b%0d", i), rd_data, 16'h0200 + i);
    end
    check("wrap_count0", count, 0);
    check("wrap_empty", empty, 1);

    // Full + rd + wr
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 1'b0, 4'd0, 16'h0300 + 16'(i)); tick();
    end
    drive(1'b1, 1'b1, 1'b1, 4'd0, 16'hBEEF); tick();
    check("frw_data", rd_data, 16'h0300);
    check("frw_valid", rd_valid, 1);
    check("frw_wr_err", wr_err, 1);
    check("frw_count", count, 15);
    check("frw_full", full, 0);
    clear = 1'b1; rd_en = 1'b1; wr_en = 1'b1; tick();
    check("clr_count", count, 0);
    check("clr_empty", empty, 1);
    check("clr_valid", rd_valid, 0);
    check("clr_wr_err", wr_err, 0);

    // Empty + rd + wr, then count=5 + rd + wr
    drive(1'b1, 1'b1, 1'b1, 4'd0, 16'h0777); tick();
    check("erw_rd_err", rd_err, 1);
    check("erw_valid", rd_valid, 0);
    check("erw_count", count, 1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, 4'd0, 16'h0400 + 16'(i)); tick();
    end
    check("c5_count", count, 5);
    drive(1'b1, 1'b1, 1'b1, 4'd0, 16'h0555); tick();
    check("c5rw_count", count, 5);
    check("c5rw_data", rd_data, 16'h0777);
    check("c5rw_err", wr_err | rd_err, 0);

    // Grow to 7 (rd_ptr=1), random access leaves stream state alone, then clear
    drive(1'b1, 1'b1, 1'b0, 4'd0, 16'h0600); tick();
    drive(1'b1, 1'b1, 1'b0, 4'd0, 16'h0601); tick();
    check("c7_count", count, 7);
    drive(1'b0, 1'b0, 1'b1, 4'd2, 16'h0); tick();
    check("mix_data", rd_data, 16'h0401);
    check("mix_count", count, 7);
    clear = 1'b1; tick();
    check("clr7_count", count, 0);
    check("clr7_empty", empty, 1);
    drive(1'b0, 1'b0, 1'b1, 4'd1, 16'h0); tick();
    check("clr7_keep", rd_data, 16'h0400);
    check("clr7_valid", rd_valid, 1);

    // Reset during a read
    drive(1'b0, 1'b0, 1'b1, 4'd1, 16'h0); rst = 1'b1; tick();
    check("rstrd_valid", rd_valid, 0);
    check("rstrd_data", rd_data, 0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 4'd0, 16'h0); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/receiver_buffer_mem.md
# receiver_buffer_mem

Parametrised receive-side storage block, the successor to the fixed 16×16 receiver memory. It provides two access modes over one synchronous single-port-per-direction array: random access by address, and stream mode with internal write/read pointers, occupancy count and full/empty flags. It sits between the receiver deserialiser, which writes words, and the consumer logic, which reads them. Reads are registered and flagged with a valid strobe.

## Interface
Parameters:
- DATA_W, 16, word width in bits
- ADDR_W, 4, address width; depth = 2^ADDR_W words

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- mode  input  1  0 = random access, 1 = stream (FIFO) access
- clear  input  1  stream-state clear: pointers and count to 0
- addr  input  ADDR_W  word address, used in random mode only
- wr_en  input  1  write request
- wr_data  input  DATA_W  write data
- rd_en  input  1  read request
- rd_data  output  DATA_W  registered read data
- rd_valid  output  1  one-cycle strobe, rd_data updated this cycle
- count  output  ADDR_W+1  stream occupancy, 0..2^ADDR_W
- empty  output  1  count == 0
- full  output  1  count == 2^ADDR_W
- wr_err  output  1  one-cycle strobe, stream write rejected (full)
- rd_err  output  1  one-cycle strobe, stream read rejected (empty)

## Operation
- Reset (rst=1 at edge): rd_data=0, rd_valid=0, wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, wr_err=0, rd_err=0. Memory array is not cleared.
- Priority each cycle: rst > clear > normal access.
- clear=1: wr_ptr, rd_ptr and count go to 0; no access is performed; rd_valid, wr_err and rd_err are 0. Memory contents are kept.
- mode is sampled every cycle. Switching mode does not touch the pointers or count.
- Random mode (mode=0):
  - wr_en: mem[addr] <= wr_data.
  - rd_en: rd_data <= mem[addr], rd_valid=1 next cycle.
  - Both asserted on the same addr: read returns the old word (read-before-write).
  - Pointers, count, wr_err and rd_err are unchanged/0.
- Stream mode (mode=1):
  - Write is accepted iff !full: mem[wr_ptr] <= wr_data, wr_ptr++. Otherwise wr_err=1 next cycle and nothing is stored.
  - Read is accepted iff !empty: rd_data <= mem[rd_ptr], rd_ptr++, rd_valid=1. Otherwise rd_err=1 next cycle and rd_data holds.
  - Acceptance is judged on the pre-edge count:
    - Full + rd + wr: read accepted, write rejected.
    - Empty + rd + wr: write accepted, read rejected.
  - count += (write accepted) − (read accepted); both accepted leaves count unchanged.
  - Pointers are ADDR_W bits and wrap from 2^ADDR_W−1 to 0.
- rd_data holds its last value whenever no read is accepted.
- empty and full are registered and consistent with count in the same cycle.

## Timing
- Write latency: data is in the array at the edge where wr_en is sampled; a read of it in the following cycle returns the new data.
- Read latency: 1 cycle. rd_data and rd_valid are valid in the cycle after rd_en is sampled.
- Back-to-back reads every cycle give rd_valid high continuously.
- count, empty and full update 1 cycle after the accepted access.
- wr_err and rd_err are single-cycle pulses, aligned with the cycle in which rd_valid would have been asserted.
- No combinational path exists from inputs to outputs.

## Test plan
- Reset, then idle: all outputs match the reset values; empty=1, count=0.
- Random mode, DATA_W=16, ADDR_W=4: write 0xA5A5 to addr 3, then read addr 3 -> next cycle rd_data=0xA5A5, rd_valid=1. Simultaneous rd/wr to addr 3 with 0x1234 -> rd_data=0xA5A5, and a later read returns 0x1234.
- Stream fill: write 0x0000..0x000F -> count=16 and full=1. A 17th write -> wr_err pulse, count stays 16. Read 16 words -> data 0x0000..0x000F in order, rd_valid each cycle, then empty=1; a further read -> rd_err pulse.
- Wrap-around: write 12 words, read 12, then write 8 more -> wr_ptr wraps to 4. Reading 8 words returns them in order; count ends at 0.
- Simultaneous events:
  - Full + rd + wr -> read accepted, wr_err=1, count 16->15.
  - Empty + rd + wr -> rd_err=1, count 0->1.
  - count=5 + rd + wr -> count stays 5.
- clear and rst mid-operation:
  - With count=7, clear -> count=0, empty=1; memory at former rd_ptr remains readable in random mode.
  - rst asserted during a read -> rd_valid=0 and rd_data=0 next cycle.
